// File: rtl/calf_port_alloc_pkg.sv
// rtl/calf_port_alloc_pkg.sv - shared widths, field positions and port indices for the CALF allocator
`ifndef CALF_PORT_ALLOC_DEFS
`define CALF_PORT_ALLOC_DEFS
`define CALF_CONTROL_W 13
`define CALF_RMATRIX_W 4
`define CALF_VALID_F 12
`define CALF_DESTX_F 1:0
`define CALF_DESTY_F 3:2
`endif

package calf_port_alloc_pkg;
  localparam int CONTROL_W = `CALF_CONTROL_W;
  localparam int RMATRIX_W = `CALF_RMATRIX_W;
  localparam int VALID_F   = `CALF_VALID_F;
  localparam int NPORTS    = 4;
  localparam int PORT_N    = 0;
  localparam int PORT_S    = 1;
  localparam int PORT_E    = 2;
  localparam int PORT_W    = 3;
  // Per-cycle deflection count (0..4)
  localparam int DEFL_W    = 3;

  function automatic logic [NPORTS-1:0] lowest_onehot(input logic [NPORTS-1:0] v);
    return v & (~v + 1'b1);
  endfunction
endpackage

// File: rtl/calf_port_pick.sv
// rtl/calf_port_pick.sv - one allocation step: productive port if free, else lowest free port (deflection)
module calf_port_pick
  import calf_port_alloc_pkg::*;
(
  input  logic [NPORTS-1:0] free,
  input  logic [NPORTS-1:0] req,
  input  logic              vld,
  output logic [NPORTS-1:0] grant,
  output logic              defl
);
  logic [NPORTS-1:0] hit;

  always_comb begin
    grant = '0;
    defl  = 1'b0;
    hit   = req & free;
    if (vld) begin
      if (|hit) begin
        grant = lowest_onehot(hit);
      end else begin
        grant = lowest_onehot(free);
        defl  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/calf_port_alloc.sv
// rtl/calf_port_alloc.sv - registered output-port allocator for the CALF bufferless deflection router
module calf_port_alloc
  import calf_port_alloc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CONTROL_W-1:0] in_ctl_n,
  input  logic [CONTROL_W-1:0] in_ctl_s,
  input  logic [CONTROL_W-1:0] in_ctl_e,
  input  logic [CONTROL_W-1:0] in_ctl_w,
  input  logic [DATA_W-1:0]    in_data_n,
  input  logic [DATA_W-1:0]    in_data_s,
  input  logic [DATA_W-1:0]    in_data_e,
  input  logic [DATA_W-1:0]    in_data_w,
  input  logic [RMATRIX_W-1:0] in_rmatrix_n,
  input  logic [RMATRIX_W-1:0] in_rmatrix_s,
  input  logic [RMATRIX_W-1:0] in_rmatrix_e,
  input  logic [RMATRIX_W-1:0] in_rmatrix_w,
  input  logic [CONTROL_W-1:0] inj_ctl,
  input  logic [DATA_W-1:0]    inj_data,
  output logic                 inj_ack,
  output logic [CONTROL_W-1:0] out_ctl_n,
  output logic [CONTROL_W-1:0] out_ctl_s,
  output logic [CONTROL_W-1:0] out_ctl_e,
  output logic [CONTROL_W-1:0] out_ctl_w,
  output logic [DATA_W-1:0]    out_data_n,
  output logic [DATA_W-1:0]    out_data_s,
  output logic [DATA_W-1:0]    out_data_e,
  output logic [DATA_W-1:0]    out_data_w,
  output logic [CONTROL_W-1:0] ej_ctl,
  output logic [DATA_W-1:0]    ej_data,
  output logic [CNT_W-1:0]     defl_cnt,
  input  logic                 stat_clr
);
  logic [NPORTS-1:0][CONTROL_W-1:0] ctl;
  logic [NPORTS-1:0][DATA_W-1:0]    data;
  logic [NPORTS-1:0][RMATRIX_W-1:0] rm;
  logic [NPORTS-1:0]                pres;

  assign ctl[PORT_N] = in_ctl_n;  assign data[PORT_N] = in_data_n;  assign rm[PORT_N] = in_rmatrix_n;
  assign ctl[PORT_S] = in_ctl_s;  assign data[PORT_S] = in_data_s;  assign rm[PORT_S] = in_rmatrix_s;
  assign ctl[PORT_E] = in_ctl_e;  assign data[PORT_E] = in_data_e;  assign rm[PORT_E] = in_rmatrix_e;
  assign ctl[PORT_W] = in_ctl_w;  assign data[PORT_W] = in_data_w;  assign rm[PORT_W] = in_rmatrix_w;

  always_comb begin
    for (int i = 0; i < NPORTS; i++) pres[i] = ctl[i][VALID_F];
  end

  logic [1:0]                    ptr;
  logic [NPORTS-1:0][1:0]        st_src;
  logic [NPORTS-1:0]             st_eject;
  logic [NPORTS-1:0]             st_vld;
  logic [NPORTS-1:0][NPORTS-1:0] st_req;
  logic [NPORTS:0][NPORTS-1:0]   st_free;
  logic [NPORTS-1:0][NPORTS-1:0] st_grant;
  logic [NPORTS-1:0]             st_defl;
  logic                          ej_busy;

  // Rotate inputs into service order and settle the single eject slot first
  always_comb begin
    ej_busy = 1'b0;
    for (int k = 0; k < NPORTS; k++) begin
      st_src[k]   = ptr + 2'(k);
      st_eject[k] = pres[st_src[k]] && (rm[st_src[k]] == '0) && !ej_busy;
      if (st_eject[k]) ej_busy = 1'b1;
      st_vld[k]   = pres[st_src[k]] && !st_eject[k];
      st_req[k]   = rm[st_src[k]];
    end
  end

  assign st_free[0] = '1;

  for (genvar g = 0; g < NPORTS; g++) begin : g_stage
    calf_port_pick u_pick (
      .free  (st_free[g]),
      .req   (st_req[g]),
      .vld   (st_vld[g]),
      .grant (st_grant[g]),
      .defl  (st_defl[g])
    );
    assign st_free[g+1] = st_free[g] & ~st_grant[g];
  end

  logic [NPORTS-1:0] inj_grant;
  logic              inj_defl_unused;

  calf_port_pick u_inj (
    .free  (st_free[NPORTS]),
    .req   ('1),
    .vld   (inj_ctl[VALID_F]),
    .grant (inj_grant),
    .defl  (inj_defl_unused)
  );

  assign inj_ack = rst_n && (|inj_grant);

  logic [NPORTS-1:0][CONTROL_W-1:0] nxt_ctl;
  logic [NPORTS-1:0][DATA_W-1:0]    nxt_data;
  logic [CONTROL_W-1:0]             nxt_ej_ctl;
  logic [DATA_W-1:0]                nxt_ej_data;
  logic [DEFL_W-1:0]                defl_sum;

  always_comb begin
    nxt_ctl     = '0;
    nxt_data    = '0;
    nxt_ej_ctl  = '0;
    nxt_ej_data = '0;
    defl_sum    = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (st_eject[k]) begin
        nxt_ej_ctl  = ctl[st_src[k]];
        nxt_ej_data = data[st_src[k]];
      end
      for (int p = 0; p < NPORTS; p++) begin
        if (st_grant[k][p]) begin
          nxt_ctl[p]  = ctl[st_src[k]];
          nxt_data[p] = data[st_src[k]];
        end
      end
      defl_sum = defl_sum + DEFL_W'(st_defl[k]);
    end
    for (int p = 0; p < NPORTS; p++) begin
      if (inj_grant[p]) begin
        nxt_ctl[p]  = inj_ctl;
        nxt_data[p] = inj_data;
      end
    end
  end

  logic [CNT_W:0] cnt_sum;
  assign cnt_sum = {1'b0, defl_cnt} + (CNT_W+1)'(defl_sum);

  logic [NPORTS-1:0][CONTROL_W-1:0] out_ctl_q;
  logic [NPORTS-1:0][DATA_W-1:0]    out_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ctl_q  <= '0;
      out_data_q <= '0;
      ej_ctl     <= '0;
      ej_data    <= '0;
      ptr        <= '0;
      defl_cnt   <= '0;
    end else begin
      out_ctl_q  <= nxt_ctl;
      out_data_q <= nxt_data;
      ej_ctl     <= nxt_ej_ctl;
      ej_data    <= nxt_ej_data;
      if (|pres) ptr <= ptr + 2'd1;
      if (stat_clr)             defl_cnt <= '0;
      else if (cnt_sum[CNT_W])  defl_cnt <= '1;
      else                      defl_cnt <= cnt_sum[CNT_W-1:0];
    end
  end

  assign out_ctl_n  = out_ctl_q[PORT_N];   assign out_data_n = out_data_q[PORT_N];
  assign out_ctl_s  = out_ctl_q[PORT_S];   assign out_data_s = out_data_q[PORT_S];
  assign out_ctl_e  = out_ctl_q[PORT_E];   assign out_data_e = out_data_q[PORT_E];
  assign out_ctl_w  = out_ctl_q[PORT_W];   assign out_data_w = out_data_q[PORT_W];
endmodule

// File: tb/tb_calf_port_alloc.sv
// tb/tb_calf_port_alloc.sv - directed self-checking bench for calf_port_alloc
module tb_calf_port_alloc;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stat_clr;
  logic [12:0] ic [4];
  logic [15:0] id [4];
  logic [3:0]  ir [4];
  logic [12:0] inj_ctl;
  logic [15:0] inj_data;
  logic        inj_ack;
  logic [12:0] oc [4];
  logic [15:0] od [4];
  logic [12:0] ej_ctl;
  logic [15:0] ej_data;
  logic [15:0] defl_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  calf_port_alloc #(.DATA_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_ctl_n(ic[0]), .in_ctl_s(ic[1]), .in_ctl_e(ic[2]), .in_ctl_w(ic[3]),
    .in_data_n(id[0]), .in_data_s(id[1]), .in_data_e(id[2]), .in_data_w(id[3]),
    .in_rmatrix_n(ir[0]), .in_rmatrix_s(ir[1]), .in_rmatrix_e(ir[2]), .in_rmatrix_w(ir[3]),
    .inj_ctl(inj_ctl), .inj_data(inj_data), .inj_ack(inj_ack),
    .out_ctl_n(oc[0]), .out_ctl_s(oc[1]), .out_ctl_e(oc[2]), .out_ctl_w(oc[3]),
    .out_data_n(od[0]), .out_data_s(od[1]), .out_data_e(od[2]), .out_data_w(od[3]),
    .ej_ctl(ej_ctl), .ej_data(ej_data), .defl_cnt(defl_cnt), .stat_clr(stat_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] mk_ctl(input logic [3:0] seq, input logic [3:0] src);
    return {1'b1, seq, src, 4'h5};
  endfunction

  task automatic flit(input int i, input logic [3:0] seq, input logic [15:0] d, input logic [3:0] r);
    ic[i] = mk_ctl(seq, 4'(i));
    id[i] = d;
    ir[i] = r;
  endtask

  task automatic clear_in();
    for (int i = 0; i < 4; i++) begin
      ic[i] = '0; id[i] = '0; ir[i] = '0;
    end
    inj_ctl = '0; inj_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs_zero(input string tag);
    for (int p = 0; p < 4; p++) begin
      check({tag, "_ctl"}, 32'(oc[p]), 32'h0);
      check({tag, "_data"}, 32'(od[p]), 32'h0);
    end
    check({tag, "_ej_ctl"}, 32'(ej_ctl), 32'h0);
    check({tag, "_ej_data"}, 32'(ej_data), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    stat_clr = 1'b0;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    check_outs_zero("por");
    check("por_cnt", 32'(defl_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Live traffic, then asynchronous reset mid-cycle
    flit(0, 4'h1, 16'h1100, 4'b0001);
    flit(1, 4'h1, 16'h1101, 4'b0001);
    flit(2, 4'h1, 16'h1102, 4'b0001);
    flit(3, 4'h1, 16'h1103, 4'b0001);
    step();
    step();
    check("pre_rst_cnt", 32'(defl_cnt), 32'd6);
    ic[3] = '0;
    inj_ctl = mk_ctl(4'h9, 4'hF);
    inj_data = 16'h7777;
    #1;
    check("pre_rst_ack", 32'(inj_ack), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check_outs_zero("rst");
    check("rst_cnt", 32'(defl_cnt), 32'h0);
    check("rst_ack", 32'(inj_ack), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_in();

    // Conflict at ptr=0: N and S both want East
    flit(0, 4'h2, 16'hA001, 4'b0100);
    flit(1, 4'h2, 16'hA002, 4'b0100);
    step();
    check("cf_e_data", 32'(od[2]), 32'hA001);
    check("cf_e_ctl", 32'(oc[2]), 32'(mk_ctl(4'h2, 4'h0)));
    check("cf_n_data", 32'(od[0]), 32'hA002);
    check("cf_s_ctl", 32'(oc[1]), 32'h0);
    check("cf_cnt", 32'(defl_cnt), 32'd1);

    // Same conflict at ptr=1: S now wins
    flit(0, 4'h3, 16'hA011, 4'b0100);
    flit(1, 4'h3, 16'hA012, 4'b0100);
    step();
    check("cf1_e_data", 32'(od[2]), 32'hA012);
    check("cf1_n_data", 32'(od[0]), 32'hA011);
    check("cf1_cnt", 32'(defl_cnt), 32'd2);

    // Dual eject at ptr=2
    clear_in();
    flit(2, 4'h4, 16'hB002, 4'b0000);
    flit(3, 4'h4, 16'hB003, 4'b0000);
    step();
    check("de_ej_data", 32'(ej_data), 32'hB002);
    check("de_ej_ctl", 32'(ej_ctl), 32'(mk_ctl(4'h4, 4'h2)));
    check("de_n_data", 32'(od[0]), 32'hB003);
    check("de_cnt", 32'(defl_cnt), 32'd3);

    // Full load at ptr=3, injection refused
    clear_in();
    flit(0, 4'h5, 16'hC000, 4'b0100);
    flit(1, 4'h5, 16'hC001, 4'b1000);
    flit(2, 4'h5, 16'hC002, 4'b0001);
    flit(3, 4'h5, 16'hC003, 4'b0010);
    inj_ctl = mk_ctl(4'hA, 4'hF);
    inj_data = 16'hD00D;
    #1;
    check("fl_ack", 32'(inj_ack), 32'h0);
    step();
    check("fl_e", 32'(od[2]), 32'hC000);
    check("fl_w", 32'(od[3]), 32'hC001);
    check("fl_n", 32'(od[0]), 32'hC002);
    check("fl_s", 32'(od[1]), 32'hC003);
    check("fl_ej", 32'(ej_ctl), 32'h0);
    check("fl_cnt", 32'(defl_cnt), 32'd3);

    // W dropped: injection fills the freed South port
    ic[3] = '0;
    #1;
    check("inj_ack", 32'(inj_ack), 32'h1);
    step();
    check("inj_s_data", 32'(od[1]), 32'hD00D);
    check("inj_s_ctl", 32'(oc[1]), 32'(mk_ctl(4'hA, 4'hF)));
    check("inj_n", 32'(od[0]), 32'hC002);
    check("inj_cnt", 32'(defl_cnt), 32'd3);

    // Idle five cycles (ptr now 1 and must hold)
    clear_in();
    for (int c = 0; c < 5; c++) begin
      step();
      check_outs_zero("idle");
    end
    // Injection alone: lowest port, never the eject slot, ptr still held
    inj_ctl = mk_ctl(4'hB, 4'hF);
    inj_data = 16'hE00E;
    step();
    check("ij_n", 32'(od[0]), 32'hE00E);
    check("ij_ej", 32'(ej_ctl), 32'h0);
    clear_in();
    flit(0, 4'h6, 16'hA021, 4'b0100);
    flit(1, 4'h6, 16'hA022, 4'b0100);
    step();
    check("hold_e", 32'(od[2]), 32'hA022);
    check("hold_n", 32'(od[0]), 32'hA021);
    check("hold_cnt", 32'(defl_cnt), 32'd4);

    // Saturation: three deflections per cycle, clear beats increment
    clear_in();
    for (int i = 0; i < 4; i++) flit(i, 4'h7, 16'hF000 + 16'(i), 4'b0001);
    stat_clr = 1'b1;
    step();
    check("clr_cnt", 32'(defl_cnt), 32'h0);
    stat_clr = 1'b0;
    for (int c = 0; c < 21845; c++) @(posedge clk);
    #1;
    check("sat_cnt", 32'(defl_cnt), 32'hFFFF);
    step();
    check("sat_hold", 32'(defl_cnt), 32'hFFFF);
    stat_clr = 1'b1;
    step();
    check("sat_clr", 32'(defl_cnt), 32'h0);
    stat_clr = 1'b0;
    step();
    check("post_clr", 32'(defl_cnt), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/calf_port_alloc.md
# calf_port_alloc

Registered output-port allocator for the CALF bufferless deflection router, directly downstream of the four per-input route-compute instances. Each cycle it:
- takes up to four arriving flits (N/S/E/W), each with its route-compute request vector;
- ejects at most one flit that has reached its destination;
- grants productive output ports in rotating priority order and deflects losers to free ports;
- admits one local injection into a leftover port;
- registers the results onto the four output links and the eject port.

## Interface
Parameters:
- DATA_W, 16, flit payload width.
- CNT_W, 16, width of the saturating deflection counter.

Ports:
- clk  in  1  router clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- in_ctl_{n,s,e,w}  in  `control_w each  arriving control words: [12] valid, [11:8] seq, [7:4] source, [3:0] dest.
- in_data_{n,s,e,w}  in  DATA_W each  arriving payloads.
- in_rmatrix_{n,s,e,w}  in  `rmatrix_w each  request vectors {W,E,S,N} = bits [3:0]; 0 with valid set means at destination.
- inj_ctl  in  `control_w  local injection control word; bit 12 is inject request.
- inj_data  in  DATA_W  local injection payload.
- inj_ack  out  1  combinational; the injection is taken this cycle.
- out_ctl_{n,s,e,w}  out  `control_w each  registered outgoing control words.
- out_data_{n,s,e,w}  out  DATA_W each  registered outgoing payloads.
- ej_ctl  out  `control_w  registered ejected control word.
- ej_data  out  DATA_W  registered ejected payload.
- defl_cnt  out  CNT_W  saturating count of deflected flits.
- stat_clr  in  1  synchronous clear of defl_cnt.

## Operation
- Input index order is N=0, S=1, E=2, W=3, matching the rmatrix bit order. A flit is present iff control bit 12 is set; rmatrix is ignored otherwise.
- A 2-bit priority pointer ptr gives the first input served. Inputs are visited ptr, ptr+1, ... mod 4. For each present flit:
  1. If rmatrix==0 and the eject slot is free: take the eject slot.
  2. Otherwise, if any rmatrix bit names a still-free output: take the lowest-index such output.
  3. Otherwise, deflect to the lowest-index free output and count one deflection. A second at-destination flit is always deflected this way.
- A free output always exists: at most 4 flits compete for 4 outputs.
- Injection: if inj_ctl[12] is set and at least one output is still free after all arrivals, inj_ack=1 and the flit takes the lowest-index free output. Injection never uses the eject slot.
- An unassigned output or eject slot carries control 0 and data 0.
- ptr advances by 1 (wrapping 3->0) on every cycle in which at least one input flit is present. It holds otherwise.
- defl_cnt adds this cycle's deflection count (0..4) and saturates at all-ones. When stat_clr=1 the counter loads 0; clear beats increment in the same cycle.
- Control words and payloads pass through unmodified.

## Timing
- Allocation is combinational from the inputs. All outputs except inj_ack are registered. Latency from input to out_*/ej_* is 1 cycle.
- No backpressure. Every arriving flit appears on exactly one output or the eject port in the next cycle; flits are never dropped or duplicated.
- On reset (async assert): all out_ctl/out_data/ej_ctl/ej_data = 0, ptr = 0, defl_cnt = 0.
- While rst_n is low, inj_ack = 0.
- After rst_n deasserts, the first clock edge samples live inputs; no warm-up cycle.

## Structure
- Shared defines: `control_w, `rmatrix_w, `valid_f, `destx_f, `desty_f, plus new constants for port indices (PORT_N..PORT_W) and the deflection-count width.
- One natural sub-module: calf_port_pick. It is combinational: given a free-port mask and a request vector, it returns the one-hot grant and a deflect flag. The allocator chains four instances in rotated order, plus one for injection.

## Test plan
- Reset mid-traffic: assert rst_n=0 with all four inputs valid -> all outputs 0 immediately, defl_cnt=0; release -> next edge samples fresh inputs with ptr=0.
- Conflict: ptr=0, N and S both present with rmatrix 4'b0100 (East) -> next cycle out_e carries N's flit, out_n carries S's flit, defl_cnt=1, ptr=1.
- Dual eject: ptr=2, E and W both present with rmatrix 0 -> ej carries E's flit, out_n carries W's flit, defl_cnt=1.
- Full load plus injection: four flits, each with a distinct productive port -> no deflections, inj_ack=0. Drop one input -> inj_ack=1 and the injected flit lands on the freed port.
- Saturation and clear: preload traffic to reach defl_cnt=16'hFFFF, deflect again -> stays FFFF. Pulse stat_clr in a deflecting cycle -> defl_cnt=0.
- Idle: no inputs present for 5 cycles -> ptr unchanged, all outputs 0.
